// File: rtl/fetch_unit.sv
// Instruction fetch front end: issues sequential reads, buffers returned
// instructions in a small queue for decode, and handles branch redirects.
module fetch_unit #(
    parameter int DEPTH = 4,
    parameter int AW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] pc_out,
    output logic          PC_write,
    output logic [AW-1:0] pc_in,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic [31:0]   imem_rdata,
    input  logic          redirect_valid,
    input  logic [AW-1:0] redirect_pc,
    output logic          if_valid,
    output logic [31:0]   if_instr,
    output logic [AW-1:0] if_pc,
    input  logic          if_ready,
    output logic          redirect_err,
    output logic [1:0]    dbg_state_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [1:0] S_RUN   = 2'd0;
    localparam logic [1:0] S_FULL  = 2'd1;
    localparam logic [1:0] S_REDIR = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic          inf_vld_q;
    logic [AW-1:0] inf_addr_q;
    logic          err_q;
    logic [31:0]   mem_instr_q [DEPTH];
    logic [AW-1:0] mem_pc_q    [DEPTH];

    logic          redir_take;
    logic [CW:0]   occ;
    logic          room;
    logic          fetch;
    logic          push;
    logic          pop;

    // A zero target is a malformed redirect: it only raises the sticky error.
    assign redir_take = redirect_valid && (redirect_pc != '0);
    assign occ        = {1'b0, count_q} + {{CW{1'b0}}, inf_vld_q};
    assign room       = occ < (CW+1)'(DEPTH);
    assign fetch      = !rst && !redir_take && (state_q == S_RUN) && room;

    // Decode handshake: the head transfers on a cycle where if_valid && if_ready;
    // if_valid never depends on if_ready, and if_ready is don't-care while if_valid=0.
    assign if_valid = !rst && (count_q != '0);
    assign pop      = if_valid && if_ready && !redir_take;
    assign push     = !rst && inf_vld_q && !redir_take;

    assign imem_req     = fetch;
    assign imem_addr    = fetch ? pc_out : '0;
    assign PC_write     = !rst && (redir_take || fetch);
    assign pc_in        = (!rst && redir_take) ? redirect_pc : '0;
    assign if_instr     = mem_instr_q[rd_ptr_q];
    assign if_pc        = mem_pc_q[rd_ptr_q];
    assign redirect_err = err_q && !rst;
    assign dbg_state_o  = state_q;

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        case (state_q)
            S_RUN:   if (!room) state_d = S_FULL;
            S_FULL:  if (room)  state_d = S_RUN;
            default: state_d = S_RUN;
        endcase
        if (redir_take) begin
            state_d  = S_REDIR;
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_RUN;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            inf_vld_q  <= 1'b0;
            inf_addr_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            inf_vld_q  <= fetch;
            inf_addr_q <= pc_out;
            if (redirect_valid && (redirect_pc == '0)) err_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_instr_q[wr_ptr_q] <= imem_rdata;
            mem_pc_q[wr_ptr_q]    <= inf_addr_q;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random traffic against a
// queue-based reference model with a modelled PC register and memory.
module tb_fetch_unit;

    localparam int DEPTH = 4;
    localparam int AW    = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] pc_out = '0;
    logic          PC_write;
    logic [AW-1:0] pc_in;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_rdata = '0;
    logic          redirect_valid = 1'b0;
    logic [AW-1:0] redirect_pc = '0;
    logic          if_valid;
    logic [31:0]   if_instr;
    logic [AW-1:0] if_pc;
    logic          if_ready = 1'b0;
    logic          redirect_err;
    logic [1:0]    dbg_state;

    int checks = 0;
    int errors = 0;

    // reference model: 0 = fetching, 1 = stalled on full, 2 = redirect bubble
    int            m_mode = 0;
    logic [63:0]   m_q[$];
    bit            m_inf = 0;
    logic [31:0]   m_inf_addr = '0;
    bit            m_err = 0;
    int            m_occ = 0;

    logic          e_req, e_pcw, e_valid, e_err;
    logic [31:0]   e_addr, e_pcin, e_pc, e_instr;
    logic          s_req, s_pcw;
    logic [31:0]   s_addr, s_pcin;

    fetch_unit #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst(rst), .pc_out(pc_out), .PC_write(PC_write), .pc_in(pc_in),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .if_ready(if_ready),
        .redirect_err(redirect_err), .dbg_state_o(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic compute_exp();
        m_occ   = m_q.size() + (m_inf ? 1 : 0);
        e_req   = 0; e_pcw = 0; e_valid = 0; e_err = 0;
        e_addr  = '0; e_pcin = '0; e_pc = '0; e_instr = '0;
        if (!rst) begin
            e_valid = (m_q.size() > 0);
            if (e_valid) {e_pc, e_instr} = m_q[0];
            e_err = m_err;
            if (redirect_valid && redirect_pc != 0) begin
                e_pcw  = 1;
                e_pcin = redirect_pc;
            end else if (m_mode == 0 && m_occ < DEPTH) begin
                e_req  = 1;
                e_addr = pc_out;
                e_pcw  = 1;
            end
        end
    endtask

    task automatic drive(input bit r, input bit rv, input logic [31:0] rpc, input bit rdy);
        rst = r; redirect_valid = rv; redirect_pc = rpc; if_ready = rdy;
        #2;
        compute_exp();
        s_req = imem_req; s_addr = imem_addr; s_pcw = PC_write; s_pcin = pc_in;
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
        if (rst) begin
            m_q.delete(); m_inf = 0; m_mode = 0; m_err = 0;
        end else begin
            if (redirect_valid && redirect_pc == 0) m_err = 1;
            if (redirect_valid && redirect_pc != 0) begin
                m_q.delete(); m_inf = 0; m_mode = 2;
            end else begin
                if (e_valid && if_ready) void'(m_q.pop_front());
                if (m_inf) m_q.push_back({m_inf_addr, imem_rdata});
                m_inf      = e_req;
                m_inf_addr = e_addr;
                if (m_mode == 2) m_mode = 0;
                else m_mode = (m_occ >= DEPTH) ? 1 : 0;
            end
        end
        // environment: PC register and one-cycle instruction memory
        if (rst) pc_out = '0;
        else if (s_pcw) pc_out = (s_pcin == 0) ? pc_out + 1 : s_pcin;
        if (s_req) imem_rdata = s_addr + 32'h100;
    endtask

    task automatic do_reset();
        drive(1, 0, 0, 0); advance();
        drive(1, 0, 0, 0); advance();
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            drive(1, 0, 0, 1);
            checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_imem_req: got %b exp 0", imem_req); end
            checks++; if (PC_write !== 1'b0) begin errors++; $display("FAIL reset_pc_write: got %b exp 0", PC_write); end
            checks++; if (pc_in !== 32'h0) begin errors++; $display("FAIL reset_pc_in: got %h exp 0", pc_in); end
            checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL reset_if_valid: got %b exp 0", if_valid); end
            checks++; if (redirect_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b exp 0", redirect_err); end
            advance();
        end
    endtask

    task automatic test_stream();
        do_reset();
        for (int i = 0; i < 7; i++) begin
            drive(0, 0, 0, 1);
            checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL stream_req c%0d: got %b exp 1", i, imem_req); end
            checks++; if (imem_addr !== 32'(i)) begin errors++; $display("FAIL stream_addr c%0d: got %h exp %h", i, imem_addr, i); end
            checks++; if (if_valid !== (i >= 2)) begin errors++; $display("FAIL stream_valid c%0d: got %b exp %b", i, if_valid, i >= 2); end
            if (i >= 2) begin
                checks++; if (if_pc !== 32'(i - 2)) begin errors++; $display("FAIL stream_pc c%0d: got %h exp %h", i, if_pc, i - 2); end
                checks++; if (if_instr !== 32'(i - 2 + 32'h100)) begin errors++; $display("FAIL stream_instr c%0d: got %h exp %h", i, if_instr, i - 2 + 32'h100); end
            end
            advance();
        end
    endtask

    task automatic test_full();
        int k;
        bit seen;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            drive(0, 0, 0, 0);
            checks++; if (PC_write !== (i < DEPTH)) begin errors++; $display("FAIL full_pc_write c%0d: got %b exp %b", i, PC_write, i < DEPTH); end
            if (i >= 2) begin
                checks++; if (if_valid !== 1'b1 || if_pc !== 32'h0) begin errors++; $display("FAIL full_hold c%0d: got v=%b pc=%h exp v=1 pc=0", i, if_valid, if_pc); end
            end
            advance();
        end
        k = 0; seen = 0;
        for (int i = 0; i < 10; i++) begin
            drive(0, 0, 0, 1);
            if (if_valid) begin
                checks++; if (if_pc !== 32'(k)) begin errors++; $display("FAIL full_order: got %h exp %h", if_pc, k); end
                k++;
            end
            if (imem_req && !seen) begin
                seen = 1;
                checks++; if (imem_addr !== 32'h4) begin errors++; $display("FAIL full_resume_addr: got %h exp 4", imem_addr); end
            end
            advance();
        end
        checks++; if (!seen) begin errors++; $display("FAIL full_resume: got no request exp request within 10 cycles"); end
    endtask

    task automatic test_redirect_full();
        do_reset();
        for (int i = 0; i < 8; i++) begin drive(0, 0, 0, 0); advance(); end
        drive(0, 1, 32'h40, 0);
        checks++; if (PC_write !== 1'b1 || pc_in !== 32'h40) begin errors++; $display("FAIL redir_load: got w=%b in=%h exp w=1 in=40", PC_write, pc_in); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL redir_req: got %b exp 0", imem_req); end
        advance();
        drive(0, 0, 0, 1);
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL redir_flush: got %b exp 0", if_valid); end
        checks++; if (imem_req !== 1'b0 || PC_write !== 1'b0) begin errors++; $display("FAIL redir_bubble: got req=%b w=%b exp 0 0", imem_req, PC_write); end
        advance();
        drive(0, 0, 0, 1);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin errors++; $display("FAIL redir_fetch: got req=%b addr=%h exp 1 40", imem_req, imem_addr); end
        advance();
        drive(0, 0, 0, 1);
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL redir_gap: got %b exp 0", if_valid); end
        advance();
        drive(0, 0, 0, 1);
        checks++; if (if_valid !== 1'b1 || if_pc !== 32'h40 || if_instr !== 32'h140) begin
            errors++; $display("FAIL redir_head: got v=%b pc=%h ins=%h exp 1 40 140", if_valid, if_pc, if_instr);
        end
        advance();
    endtask

    task automatic test_redirect_collide();
        logic [31:0] nxt;
        int seen;
        do_reset();
        for (int i = 0; i < 6; i++) begin drive(0, 0, 0, 1); advance(); end
        drive(0, 1, 32'h10, 1);
        advance();
        nxt = 32'h10; seen = 0;
        for (int i = 0; i < 10; i++) begin
            drive(0, 0, 0, 1);
            if (if_valid) begin
                checks++; if (if_pc !== nxt) begin errors++; $display("FAIL collide_pc: got %h exp %h", if_pc, nxt); end
                nxt++; seen++;
            end
            advance();
        end
        checks++; if (seen < 5) begin errors++; $display("FAIL collide_progress: got %0d heads exp >=5", seen); end
    endtask

    task automatic test_redirect_zero();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(0, i == 2, 0, 1);
            checks++; if (imem_req !== 1'b1 || imem_addr !== 32'(i)) begin errors++; $display("FAIL zero_flow c%0d: got req=%b addr=%h exp 1 %h", i, imem_req, imem_addr, i); end
            checks++; if (redirect_err !== (i >= 3)) begin errors++; $display("FAIL zero_err c%0d: got %b exp %b", i, redirect_err, i >= 3); end
            advance();
        end
        drive(1, 0, 0, 1);
        checks++; if (redirect_err !== 1'b0) begin errors++; $display("FAIL zero_rst: got %b exp 0", redirect_err); end
        advance();
        drive(0, 0, 0, 1);
        checks++; if (redirect_err !== 1'b0) begin errors++; $display("FAIL zero_cleared: got %b exp 0", redirect_err); end
        advance();
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 6; i++) begin drive(0, 0, 0, 0); advance(); end
        for (int k = 0; k < 12; k++) begin
            drive(0, 0, 0, 1);
            checks++; if (if_valid !== 1'b1 || if_pc !== 32'(k)) begin errors++; $display("FAIL b2b c%0d: got v=%b pc=%h exp 1 %h", k, if_valid, if_pc, k); end
            advance();
        end
    endtask

    task automatic test_random();
        bit r, rv, rdy;
        logic [31:0] rpc;
        do_reset();
        for (int i = 0; i < 500; i++) begin
            r   = ($urandom_range(0, 63) == 0);
            rv  = ($urandom_range(0, 15) == 0);
            rpc = ($urandom_range(0, 3) == 0) ? 32'h0 : 32'($urandom_range(1, 200));
            rdy = ($urandom_range(0, 3) != 0);
            drive(r, rv, rpc, rdy);
            checks++; if (if_valid !== e_valid) begin errors++; $display("FAIL rnd_valid c%0d: got %b exp %b", i, if_valid, e_valid); end
            if (e_valid) begin
                checks++; if (if_pc !== e_pc || if_instr !== e_instr) begin errors++; $display("FAIL rnd_head c%0d: got %h/%h exp %h/%h", i, if_pc, if_instr, e_pc, e_instr); end
            end
            checks++; if (imem_req !== e_req) begin errors++; $display("FAIL rnd_req c%0d: got %b exp %b", i, imem_req, e_req); end
            if (e_req) begin
                checks++; if (imem_addr !== e_addr) begin errors++; $display("FAIL rnd_addr c%0d: got %h exp %h", i, imem_addr, e_addr); end
            end
            checks++; if (PC_write !== e_pcw || pc_in !== e_pcin) begin errors++; $display("FAIL rnd_pc c%0d: got %b/%h exp %b/%h", i, PC_write, pc_in, e_pcw, e_pcin); end
            checks++; if (redirect_err !== e_err) begin errors++; $display("FAIL rnd_err c%0d: got %b exp %b", i, redirect_err, e_err); end
            advance();
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_full();
        test_redirect_full();
        test_redirect_collide();
        test_redirect_zero();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
